// File: rtl/lcd_time_writer_pkg.sv
// Shared constants and enumerations for the HD44780-style clock writer.
// Covers the LCD command bytes, ASCII offsets, main FSM states and nibble-engine phases.
package lcd_time_writer_pkg;

  localparam int CNT_W = 24;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_DDRAM_HOME = 8'h80;

  localparam logic [3:0] INIT_NIB_WAKE  = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT  = 4'h2;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam logic [7:0] ASCII_COLON    = 8'h3A;

  localparam int T_SETUP = 2;
  localparam int T_PULSE = 12;
  localparam int T_HOLD  = 2;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_CFG,
    ST_CLR_WAIT,
    ST_IDLE,
    ST_WRITE
  } lcd_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD,
    PH_GAP
  } nib_phase_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/lcd_time_writer_bin2bcd6.sv
// Combinational 6-bit binary to two-digit BCD; 60..63 give tens=6, so
// out-of-range inputs display arithmetically rather than being clamped.
module bin2bcd6 (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [5:0] rem;

  always_comb begin
    tens_o = 4'd0;
    rem    = bin_i;
    if (bin_i >= 6'd60) begin
      tens_o = 4'd6;
      rem    = bin_i - 6'd60;
    end else if (bin_i >= 6'd50) begin
      tens_o = 4'd5;
      rem    = bin_i - 6'd50;
    end else if (bin_i >= 6'd40) begin
      tens_o = 4'd4;
      rem    = bin_i - 6'd40;
    end else if (bin_i >= 6'd30) begin
      tens_o = 4'd3;
      rem    = bin_i - 6'd30;
    end else if (bin_i >= 6'd20) begin
      tens_o = 4'd2;
      rem    = bin_i - 6'd20;
    end else if (bin_i >= 6'd10) begin
      tens_o = 4'd1;
      rem    = bin_i - 6'd10;
    end
    units_o = rem[3:0];
  end

endmodule

// File: rtl/lcd_time_writer.sv
// Drives a 4-bit character LCD: power-on init, configuration, then redraws
// "HH:MM:SS" on request. A nibble engine handles SETUP/PULSE/HOLD/GAP timing.
module lcd_time_writer
  import lcd_time_writer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int T_PWR   = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000,
  parameter int T_NIB   = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  sec,
  input  logic [5:0]  min,
  input  logic [4:0]  hrs,
  input  logic        update,
  output logic        busy,
  output logic [11:8] SF_D,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        SF_CE0,
  output lcd_state_e  dbg_state_o
);

  if (CLK_HZ < 1 || T_PWR < 1 || T_INIT1 < 1 || T_INIT2 < 1 ||
      T_CMD < 1 || T_CLR < 1 || T_NIB < 1) begin : g_bad_param
    $error("lcd_time_writer: CLK_HZ and all timing parameters must be positive");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  lcd_state_e       state_q, state_d;
  nib_phase_e       ph_q, ph_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] post_q, post_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       nib_q, nib_d;
  logic             rs_q, rs_d;
  logic             lo_pend_q, lo_pend_d;
  logic             pend_q, pend_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d, hrs_q, hrs_d;

  logic [CNT_W-1:0] cnt_inc, gap_len, job_post;
  logic [7:0]       job_byte;
  logic             job_rs, job_two;
  logic [3:0]       job_cnt;
  lcd_state_e       job_st;
  logic             start, finish, latch;
  logic [3:0]       h_tens, h_units, m_tens, m_units, s_tens, s_units;

  bin2bcd6 u_bcd_hrs (.bin_i(hrs_q), .tens_o(h_tens), .units_o(h_units));
  bin2bcd6 u_bcd_min (.bin_i(min_q), .tens_o(m_tens), .units_o(m_units));
  bin2bcd6 u_bcd_sec (.bin_i(sec_q), .tens_o(s_tens), .units_o(s_units));

  assign cnt_inc = cnt_q + CNT_ONE;
  assign gap_len = lo_pend_q ? CNT_W'(T_NIB) : post_q;
  // The first INIT nibble is launched on the PWR_WAIT expiry cycle itself.
  assign job_st  = (state_q == ST_PWR_WAIT) ? ST_INIT : state_q;

  always_comb begin
    job_byte = 8'h00;
    job_rs   = 1'b0;
    job_two  = 1'b1;
    job_post = CNT_W'(T_CMD);
    job_cnt  = 4'd0;
    unique case (job_st)
      ST_INIT: begin
        job_cnt  = 4'd4;
        job_two  = 1'b0;
        job_byte = (step_q == 4'd3) ? {INIT_NIB_4BIT, 4'h0} : {INIT_NIB_WAKE, 4'h0};
        if (step_q == 4'd0)      job_post = CNT_W'(T_INIT1);
        else if (step_q == 4'd1) job_post = CNT_W'(T_INIT2);
      end
      ST_CFG: begin
        job_cnt = 4'd4;
        case (step_q)
          4'd0:    job_byte = CMD_FUNC_SET;
          4'd1:    job_byte = CMD_ENTRY_MODE;
          4'd2:    job_byte = CMD_DISP_ON;
          default: job_byte = CMD_CLEAR;
        endcase
      end
      ST_WRITE: begin
        job_cnt = 4'd9;
        job_rs  = (step_q != 4'd0);
        case (step_q)
          4'd0:       job_byte = CMD_DDRAM_HOME;
          4'd1:       job_byte = ascii_digit(h_tens);
          4'd2:       job_byte = ascii_digit(h_units);
          4'd3, 4'd6: job_byte = ASCII_COLON;
          4'd4:       job_byte = ascii_digit(m_tens);
          4'd5:       job_byte = ascii_digit(m_units);
          4'd7:       job_byte = ascii_digit(s_tens);
          default:    job_byte = ascii_digit(s_units);
        endcase
      end
      default: ;
    endcase
  end

  // update is a one-cycle strobe with no ready: taken directly in IDLE,
  // otherwise folded into pend_q and served when the current work completes.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    post_d    = post_q;
    byte_d    = byte_q;
    nib_d     = nib_q;
    rs_d      = rs_q;
    lo_pend_d = lo_pend_q;
    pend_d    = pend_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hrs_d     = hrs_q;
    start     = 1'b0;
    finish    = 1'b0;
    latch     = 1'b0;

    unique case (ph_q)
      PH_IDLE: ;
      PH_SETUP: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= CNT_W'(T_SETUP)) begin
          ph_d  = PH_PULSE;
          cnt_d = '0;
        end
      end
      PH_PULSE: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= CNT_W'(T_PULSE)) begin
          ph_d  = PH_HOLD;
          cnt_d = '0;
        end
      end
      PH_HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= CNT_W'(T_HOLD)) begin
          ph_d  = PH_GAP;
          cnt_d = '0;
        end
      end
      PH_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= gap_len) begin
          cnt_d = '0;
          if (lo_pend_q) begin
            nib_d     = byte_q[3:0];
            lo_pend_d = 1'b0;
            ph_d      = PH_SETUP;
          end else begin
            ph_d = PH_IDLE;
          end
        end
      end
      default: ph_d = PH_IDLE;
    endcase

    if (update && state_q != ST_IDLE) pend_d = 1'b1;

    unique case (state_q)
      ST_PWR_WAIT: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= CNT_W'(T_PWR)) begin
          state_d = ST_INIT;
          step_d  = 4'd1;
          start   = 1'b1;
        end
      end
      ST_INIT, ST_CFG, ST_WRITE: begin
        if (ph_q == PH_IDLE) begin
          if (step_q < job_cnt) begin
            start  = 1'b1;
            step_d = step_q + 4'd1;
          end else if (state_q == ST_INIT) begin
            state_d = ST_CFG;
            step_d  = 4'd0;
          end else if (state_q == ST_CFG) begin
            state_d = ST_CLR_WAIT;
            step_d  = 4'd0;
            cnt_d   = '0;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_CLR_WAIT: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= CNT_W'(T_CLR)) begin
          cnt_d  = '0;
          finish = 1'b1;
        end
      end
      ST_IDLE: begin
        if (update) begin
          latch   = 1'b1;
          state_d = ST_WRITE;
          step_d  = 4'd0;
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase

    // A pending request chains straight into the next WRITE so busy never dips.
    if (finish) begin
      step_d = 4'd0;
      if (pend_q || update) begin
        latch   = 1'b1;
        pend_d  = 1'b0;
        state_d = ST_WRITE;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (start) begin
      byte_d    = job_byte;
      nib_d     = job_byte[7:4];
      rs_d      = job_rs;
      lo_pend_d = job_two;
      post_d    = job_post;
      ph_d      = PH_SETUP;
      cnt_d     = '0;
    end

    if (latch) begin
      sec_d = sec;
      min_d = min;
      hrs_d = {1'b0, hrs};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PWR_WAIT;
      ph_q      <= PH_IDLE;
      step_q    <= 4'd0;
      cnt_q     <= '0;
      post_q    <= '0;
      byte_q    <= 8'h00;
      nib_q     <= 4'h0;
      rs_q      <= 1'b0;
      lo_pend_q <= 1'b0;
      pend_q    <= 1'b0;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      hrs_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      post_q    <= post_d;
      byte_q    <= byte_d;
      nib_q     <= nib_d;
      rs_q      <= rs_d;
      lo_pend_q <= lo_pend_d;
      pend_q    <= pend_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hrs_q     <= hrs_d;
    end
  end

  assign LCD_E       = (ph_q == PH_PULSE);
  assign LCD_RS      = rs_q;
  assign SF_D        = nib_q;
  assign LCD_RW      = 1'b0;
  assign SF_CE0      = 1'b1;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_time_writer.sv
// Self-checking bench for lcd_time_writer with scaled timing parameters.
// Every nibble strobed on LCD_E is popped from an expected queue of {RS, nibble}.
module tb_lcd_time_writer;
  import lcd_time_writer_pkg::*;

  localparam int W       = 5;
  localparam int P_PWR   = 20;
  localparam int P_INIT1 = 10;
  localparam int P_INIT2 = 5;
  localparam int P_CMD   = 4;
  localparam int P_CLR   = 8;
  localparam int P_NIB   = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  sec, min;
  logic [4:0]  hrs;
  logic        update;
  logic        busy;
  logic [11:8] SF_D;
  logic        LCD_E, LCD_RS, LCD_RW, SF_CE0;
  lcd_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [W-1:0] exp_q[$];

  lcd_time_writer #(
    .CLK_HZ(50_000_000), .T_PWR(P_PWR), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2),
    .T_CMD(P_CMD), .T_CLR(P_CLR), .T_NIB(P_NIB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sec(sec), .min(min), .hrs(hrs),
    .update(update), .busy(busy), .SF_D(SF_D), .LCD_E(LCD_E),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .SF_CE0(SF_CE0), .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // expected-stream model
  function automatic void push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endfunction

  function automatic void push_powerup();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endfunction

  function automatic void push_redraw(input int h, input int m, input int s);
    push_byte(1'b0, 8'h80);
    push_byte(1'b1, 8'(48 + h / 10));
    push_byte(1'b1, 8'(48 + h % 10));
    push_byte(1'b1, 8'h3A);
    push_byte(1'b1, 8'(48 + m / 10));
    push_byte(1'b1, 8'(48 + m % 10));
    push_byte(1'b1, 8'h3A);
    push_byte(1'b1, 8'(48 + s / 10));
    push_byte(1'b1, 8'(48 + s % 10));
  endfunction

  // protocol checker and scoreboard consumer
  logic [W-1:0] cur, h1, h2, e_val, exp_nib;
  logic e_prev;
  int   hi_cnt, last_fall;
  bit   post_left;
  bit   watch_busy = 1'b0;
  int   busy_drops = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      e_prev = 1'b0; hi_cnt = 0; post_left = 1'b0; h1 = '0; h2 = '0;
    end else begin
      cur = {LCD_RS, SF_D};
      check("rw_low", 32'(LCD_RW), 0);
      check("ce0_high", 32'(SF_CE0), 1);
      if (watch_busy && !busy) busy_drops++;
      if (LCD_E && !e_prev) begin
        check("setup_stable", 32'(h1 == cur && h2 == cur), 1);
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_nib = exp_q.pop_front();
          check("nibble", 32'(cur), 32'(exp_nib));
        end
        e_val = cur; hi_cnt = 1;
      end else if (LCD_E) begin
        hi_cnt++;
        check("pulse_stable", 32'(cur), 32'(e_val));
      end else if (e_prev) begin
        check("e_width", 32'(hi_cnt), 12);
        check("hold1", 32'(cur), 32'(e_val));
        post_left = 1'b1; last_fall = cyc;
      end else if (post_left) begin
        check("hold2", 32'(cur), 32'(e_val));
        post_left = 1'b0;
      end
      h2 = h1; h1 = cur; e_prev = LCD_E;
    end
  end

  // driver tasks
  task automatic set_time(input int h, input int m, input int s);
    hrs = 5'(h); min = 6'(m); sec = 6'(s);
  endtask

  task automatic pulse_update();
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int n = 0;
    while (busy !== val && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(busy), 32'(val));
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic release_reset(input string tag);
    int n = 0;
    @(negedge clk); reset_n = 1'b1; push_powerup();
    while (!LCD_E && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, "_first_e"}, 32'(n), 22);
    check({tag, "_first_nib"}, 32'(SF_D), 3);
  endtask

  task automatic finish_powerup(input string tag);
    wait_busy(1'b0, 2000, {tag, "_busy_fall"});
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
    check({tag, "_clr_gap"}, 32'((cyc - last_fall) >= P_CLR), 1);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic enter_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
  endtask

  initial begin
    int n, base;
    reset_n = 1'b0; update = 1'b0;
    set_time(0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 1);
    check("rst_e", 32'(LCD_E), 0);
    check("rst_rs", 32'(LCD_RS), 0);
    check("rst_sfd", 32'(SF_D), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_PWR_WAIT));

    release_reset("pwr");
    finish_powerup("pwr");

    // single redraw 09:05:07
    set_time(9, 5, 7);
    push_redraw(9, 5, 7);
    @(negedge clk); update = 1'b1;
    @(posedge clk); #1;
    check("redraw_busy_next", 32'(busy), 1);
    @(negedge clk); update = 1'b0;
    wait_drain(1000, "redraw_drain");
    wait_busy(1'b0, 200, "redraw_done");

    // out-of-range values shown arithmetically
    set_time(31, 60, 63);
    push_redraw(31, 60, 63);
    pulse_update();
    wait_drain(1000, "oor_drain");
    wait_busy(1'b0, 200, "oor_done");

    // two merged updates during a WRITE, inputs changed mid-write
    set_time(12, 34, 56);
    push_redraw(12, 34, 56);
    pulse_update();
    base = busy_drops; watch_busy = 1'b1;
    repeat (60) @(negedge clk);
    set_time(23, 59, 59);
    pulse_update();
    repeat (20) @(negedge clk);
    pulse_update();
    push_redraw(23, 59, 59);
    wait_drain(2500, "pend_drain");
    check("pend_busy_held", 32'(busy_drops - base), 0);
    watch_busy = 1'b0;
    wait_busy(1'b0, 200, "pend_done");
    repeat (200) @(negedge clk);
    check("pend_single", 32'(exp_q.size()), 0);
    check("pend_idle", 32'(busy), 0);

    // update while initialising
    enter_reset();
    release_reset("init");
    set_time(7, 8, 9);
    pulse_update();
    push_redraw(7, 8, 9);
    base = busy_drops; watch_busy = 1'b1;
    wait_drain(3000, "init_drain");
    check("init_busy_held", 32'(busy_drops - base), 0);
    watch_busy = 1'b0;
    wait_busy(1'b0, 200, "init_done");

    // reset during the PULSE of a character byte
    set_time(1, 2, 3);
    push_redraw(1, 2, 3);
    pulse_update();
    n = 0;
    while (!(LCD_E && LCD_RS) && n < 600) begin @(negedge clk); n++; end
    check("wr_pulse_seen", 32'(LCD_E && LCD_RS), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_e", 32'(LCD_E), 0);
    check("mid_rst_busy", 32'(busy), 1);
    check("mid_rst_rs", 32'(LCD_RS), 0);
    check("mid_rst_sfd", 32'(SF_D), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    release_reset("rst2");
    finish_powerup("rst2");

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
